// File: rtl/ysyx_210978_mul_issuer.sv
// ysyx_210978_mul_issuer
//   Execute-stage front end for the booth multiplier. Accepts one RV64M
//   multiply (MUL/MULH/MULHSU/MULHU/MULW) at a time from the EXU, drives the
//   multiplier's operands/sign/width controls and valid/flush handshake,
//   captures the one-cycle product pulse, and holds the selected and extended
//   64-bit writeback value until the EXU takes it.
//   A watchdog bounds the time spent waiting for the multiplier (WAIT) or for
//   it to go quiet after a cancel (DRAIN); expiry raises a sticky err.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   req_*                 : EXU request (valid/ready, op, rs1, rs2)
//   flush                 : cancel any in-flight op
//   resp_*                : writeback response (valid/ready, data)
//   busy, err             : not-idle status, sticky timeout flag
//   mul_in_valid, mul_flush, mulw, mul_signed, multiplicand, multiplier
//                         : controls/operands to the multiplier
//   mul_out_ready, mul_out_valid, result_hi, result_lo
//                         : status and product from the multiplier
module ysyx_210978_mul_issuer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        busy,
  output logic        err,
  output logic        mul_in_valid,
  output logic        mul_flush,
  output logic        mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] multiplicand,
  output logic [63:0] multiplier,
  input  logic        mul_out_ready,
  input  logic        mul_out_valid,
  input  logic [63:0] result_hi,
  input  logic [63:0] result_lo
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_e;

  state_e      state_q, state_d;
  mul_op_e     op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        mul_in_valid_q, mul_in_valid_d;
  logic        mul_flush_q, mul_flush_d;
  logic        mulw_q, mulw_d;
  logic [1:0]  mul_signed_q, mul_signed_d;
  logic [63:0] multiplicand_q, multiplicand_d;
  logic [63:0] multiplier_q, multiplier_d;

  logic [63:0] result_sel;

  // Writeback selection for the op that is in flight.
  always_comb begin
    case (op_q)
      OP_MUL:  result_sel = result_lo;
      OP_MULW: result_sel = {{32{result_lo[31]}}, result_lo[31:0]};
      default: result_sel = result_hi;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    mul_in_valid_d = mul_in_valid_q;
    mul_flush_d    = 1'b0;
    mulw_d         = mulw_q;
    mul_signed_d   = mul_signed_q;
    multiplicand_d = multiplicand_q;
    multiplier_d   = multiplier_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          // Unused encodings 5-7 behave as plain MUL.
          op_d           = (req_op > 3'd4) ? OP_MUL : mul_op_e'(req_op);
          mul_in_valid_d = 1'b1;
          state_d        = S_ISSUE;
          multiplicand_d = req_src1;
          multiplier_d   = req_src2;
          mulw_d         = 1'b0;
          case (req_op)
            3'd2: mul_signed_d = 2'b10;
            3'd3: mul_signed_d = 2'b00;
            3'd4: begin
              mul_signed_d   = 2'b11;
              mulw_d         = 1'b1;
              multiplicand_d = {{32{req_src1[31]}}, req_src1[31:0]};
              multiplier_d   = {{32{req_src2[31]}}, req_src2[31:0]};
            end
            default: mul_signed_d = 2'b11;
          endcase
        end
      end

      S_ISSUE: begin
        if (mul_out_ready) begin
          // Handshake completes at this edge; a simultaneous flush must
          // cancel the op the multiplier has just taken.
          mul_in_valid_d = 1'b0;
          cnt_d          = '0;
          if (flush) begin
            mul_flush_d = 1'b1;
            state_d     = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end else if (flush) begin
          // Multiplier never saw the op, nothing to cancel.
          mul_in_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      S_WAIT: begin
        if (flush) begin
          // Flush wins over a same-cycle result; watchdog restarts for DRAIN.
          mul_flush_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_DRAIN;
        end else if (mul_out_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = result_sel;
          state_d      = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        if (flush || resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      S_DRAIN: begin
        // Any late product from the cancelled op is discarded here.
        if (mul_out_ready && !mul_out_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= OP_MUL;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      mul_in_valid_q <= 1'b0;
      mul_flush_q    <= 1'b0;
      mulw_q         <= 1'b0;
      mul_signed_q   <= 2'b00;
      multiplicand_q <= '0;
      multiplier_q   <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      mul_in_valid_q <= mul_in_valid_d;
      mul_flush_q    <= mul_flush_d;
      mulw_q         <= mulw_d;
      mul_signed_q   <= mul_signed_d;
      multiplicand_q <= multiplicand_d;
      multiplier_q   <= multiplier_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE) && !flush;
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign mul_in_valid = mul_in_valid_q;
  assign mul_flush    = mul_flush_q;
  assign mulw         = mulw_q;
  assign mul_signed   = mul_signed_q;
  assign multiplicand = multiplicand_q;
  assign multiplier   = multiplier_q;

endmodule

// File: tb/tb_ysyx_210978_mul_issuer.sv
// Testbench for ysyx_210978_mul_issuer: a behavioural multiplier stub drives
// the multiplier side; expected writeback values come from plain 128-bit
// arithmetic on the original request operands.
module tb_ysyx_210978_mul_issuer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_src1, req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        busy, err;
  logic        mul_in_valid, mul_flush, mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand, multiplier;
  logic        mul_out_ready, mul_out_valid;
  logic [63:0] result_hi, result_lo;

  int errors = 0;
  int checks = 0;

  // Stub controls and state
  int          stub_lat = 33;
  bit          stub_never = 0;
  bit          stub_stale = 0;
  bit          stub_hold = 0;
  bit          stub_busy = 0;
  int          stub_cnt = 0;
  int          stale_cnt = 0;
  int          stale_pulses = 0;
  bit          p_acc = 0, p_flush = 0;
  logic [127:0] p_prod, stub_prod;

  ysyx_210978_mul_issuer #(.TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .err(err),
    .mul_in_valid(mul_in_valid), .mul_flush(mul_flush), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_out_ready(mul_out_ready), .mul_out_valid(mul_out_valid),
    .result_hi(result_hi), .result_lo(result_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] sx(input logic [63:0] x);
    return {{64{x[63]}}, x};
  endfunction

  function automatic logic [127:0] zx(input logic [63:0] x);
    return {64'd0, x};
  endfunction

  // Architectural RV64M result
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    case (op)
      3'd1: begin p = sx(a) * sx(b); return p[127:64]; end
      3'd2: begin p = sx(a) * zx(b); return p[127:64]; end
      3'd3: begin p = zx(a) * zx(b); return p[127:64]; end
      3'd4: begin w = a * b; return {{32{w[31]}}, w[31:0]}; end
      default: begin w = a * b; return w; end
    endcase
  endfunction

  function automatic logic [1:0] ref_signed(input logic [2:0] op);
    case (op)
      3'd2: return 2'b10;
      3'd3: return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [63:0] ref_operand(input logic [2:0] op, input logic [63:0] x);
    return (op == 3'd4) ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Multiplier stub: everything happens at negedges; p_* record what the DUT
  // and stub presented just before the following posedge.
  initial begin
    mul_out_ready = 1'b1;
    mul_out_valid = 1'b0;
    result_hi = '0;
    result_lo = '0;
    p_prod = '0;
    stub_prod = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stub_busy = 0;
        stale_cnt = 0;
      end else if (p_flush && (stub_busy || p_acc)) begin
        stub_busy = 0;
        stale_cnt = stub_stale ? 2 : 0;
      end else if (p_acc) begin
        stub_busy = 1;
        stub_cnt  = stub_lat;
        stub_prod = p_prod;
      end
      mul_out_valid = 1'b0;
      if (stale_cnt > 0) begin
        stale_cnt--;
        if (stale_cnt == 0) begin
          mul_out_valid = 1'b1;
          result_hi = {$urandom, $urandom};
          result_lo = {$urandom, $urandom};
          stale_pulses++;
        end
      end else if (stub_busy && !stub_never) begin
        if (stub_cnt == 0) begin
          mul_out_valid = 1'b1;
          {result_hi, result_lo} = stub_prod;
          stub_busy = 0;
        end else begin
          stub_cnt--;
        end
      end
      mul_out_ready = !stub_busy && (stale_cnt == 0) && !stub_hold;
      p_acc   = mul_in_valid && mul_out_ready && !reset;
      p_flush = mul_flush && !reset;
      p_prod  = (mul_signed[1] ? sx(multiplicand) : zx(multiplicand)) *
                (mul_signed[0] ? sx(multiplier)   : zx(multiplier));
    end
  end

  // One complete transaction; the response is held 'hold' cycles before acceptance.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] exp;
    int n;
    exp = ref_result(op, a, b);
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clock);
    req_valid = 1'b0; req_op = 3'($urandom); req_src1 = {$urandom, $urandom}; req_src2 = {$urandom, $urandom};
    check("issue_in_valid", 64'(mul_in_valid), 64'd1);
    check("issue_signed", 64'(mul_signed), 64'(ref_signed(op)));
    check("issue_mulw", 64'(mulw), 64'(op == 3'd4));
    check("issue_multiplicand", multiplicand, ref_operand(op, a));
    check("issue_multiplier", multiplier, ref_operand(op, b));
    @(negedge clock);
    check("in_valid_drop", 64'(mul_in_valid), 64'd0);
    n = 0;
    while (!resp_valid && n < 150) begin
      @(negedge clock);
      n++;
    end
    check("resp_seen", 64'(resp_valid), 64'd1);
    if (resp_valid) begin
      check("resp_data", resp_data, exp);
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_data", resp_data, exp);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("resp_drop", 64'(resp_valid), 64'd0);
      check("idle_after", 64'(busy), 64'd0);
    end
    $display("txn op=%0d src1=%h src2=%h resp=%h exp=%h hold=%0d", op, a, b, resp_data, exp, hold);
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n, bad, stale0;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_valid", 64'(mul_in_valid), 64'd0);
    check("rst_flush", 64'(mul_flush), 64'd0);
    check("rst_mulw", 64'(mulw), 64'd0);
    check("rst_signed", 64'(mul_signed), 64'd0);
    check("rst_multiplicand", multiplicand, 64'd0);
    check("rst_multiplier", multiplier, 64'd0);

    // Directed ops
    stub_lat = 33;
    run_op(3'd0, 64'd3, 64'd5, 3);
    run_op(3'd3, '1, '1, 0);
    run_op(3'd1, '1, '1, 0);
    run_op(3'd2, '1, 64'd2, 1);
    run_op(3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2, 0);

    // Flush in IDLE blocks acceptance only
    @(negedge clock);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0;
    #1 check("idle_flush_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    check("idle_flush_noaccept", 64'(busy), 64'd0);
    flush = 1'b0; req_valid = 1'b0;
    #1 check("idle_ready_back", 64'(req_ready), 64'd1);

    // Flush in ISSUE before the multiplier accepted: straight to IDLE, no pulse
    stub_hold = 1;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 64'd9; req_src2 = 64'd9;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b1;
    check("stall_in_valid", 64'(mul_in_valid), 64'd1);
    @(negedge clock);
    flush = 1'b0;
    check("stall_flush_idle", 64'(busy), 64'd0);
    check("stall_no_flush", 64'(mul_flush), 64'd0);
    check("stall_in_valid_low", 64'(mul_in_valid), 64'd0);
    stub_hold = 0;
    @(negedge clock);

    // Flush five cycles into WAIT, with a stale product pulse during drain
    stub_lat = 33; stub_stale = 1;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 64'd11; req_src2 = 64'd13;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    repeat (4) @(negedge clock);
    flush = 1'b1;
    stale0 = stale_pulses;
    @(negedge clock);
    flush = 1'b0;
    check("wait_flush_pulse", 64'(mul_flush), 64'd1);
    check("wait_flush_busy", 64'(busy), 64'd1);
    check("wait_flush_resp", 64'(resp_valid), 64'd0);
    @(negedge clock);
    check("wait_flush_single", 64'(mul_flush), 64'd0);
    n = 0; bad = 0;
    while (busy && n < 40) begin
      if (resp_valid || mul_flush) bad++;
      @(negedge clock);
      n++;
    end
    check("drain_exit", 64'(busy), 64'd0);
    check("drain_quiet", 64'(bad), 64'd0);
    check("drain_stale_seen", 64'(stale_pulses - stale0), 64'd1);
    check("drain_no_resp", 64'(resp_valid), 64'd0);
    stub_stale = 0;
    run_op(3'd0, 64'd7, 64'd6, 1);

    // Flush while the response is pending drops it
    stub_lat = 5;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd3; req_src1 = 64'd100; req_src2 = 64'd200;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("done_reached", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("done_flush_drop", 64'(resp_valid), 64'd0);
    check("done_flush_idle", 64'(busy), 64'd0);

    // Randomised ops
    for (int t = 0; t < 24; t++) begin
      stub_lat = $urandom_range(2, 40);
      run_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), $urandom_range(0, 3));
    end

    // Watchdog: multiplier never answers
    stub_never = 1;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd3; req_src1 = '1; req_src2 = '1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("timeout_cycles", 64'(n), 64'd64);
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_data", resp_data, 64'd0);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("timeout_idle", 64'(busy), 64'd0);
    repeat (5) @(negedge clock);
    check("err_sticky", 64'(err), 64'd1);
    $display("txn timeout cycles=%0d err=%0d", n, err);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    stub_never = 0;
    #1 check("err_cleared", 64'(err), 64'd0);
    stub_lat = 33;
    run_op(3'd0, 64'd7, 64'd6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
